simd_fir_reduce: RTL and testbench

SIMD_FIR_REDUCE -- requirements
Module: simd_fir_reduce

---
 rtl/simd_fir_reduce_pkg.sv | 9 +
 rtl/simd_fir_reduce_if.sv | 21 ++
 rtl/simd_fir_reduce_lane_tree4.sv | 12 +
 rtl/simd_fir_reduce.sv | 70 +++++++
 tb/tb_simd_fir_reduce.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/simd_fir_reduce_pkg.sv
// simd_fir_pkg: shared widths and saturation bounds for the SIMD FIR reduction path
package simd_fir_pkg;
  localparam int LANES = 16;
  localparam int LANE_W = 16;
  localparam int ACC_W = 32;
  localparam int VEC_W = 256;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;
endpackage

// File: rtl/simd_fir_reduce_if.sv
// simd_fir_reduce_if: vector beat input and finished-sample output handshakes
interface simd_fir_reduce_if;
  import simd_fir_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [VEC_W-1:0] in_data;
  logic in_last;
  logic [4:0] cfg_shift;
  logic out_valid;
  logic out_ready;
  logic [15:0] out_data;
  logic out_sat;
  modport master(
    output in_valid, in_data, in_last, cfg_shift, out_ready,
    input in_ready, out_valid, out_data, out_sat
  );
  modport slave(
    input in_valid, in_data, in_last, cfg_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/simd_fir_reduce_lane_tree4.sv
// simd_lane_tree4: signed sum of four adjacent lanes, widened by two bits so it cannot overflow
module simd_lane_tree4
  import simd_fir_pkg::*;
(
  input  logic [4*LANE_W-1:0] lanes,
  output logic signed [LANE_W+1:0] sum
);
  assign sum = (LANE_W+2)'($signed(lanes[0*LANE_W +: LANE_W]))
             + (LANE_W+2)'($signed(lanes[1*LANE_W +: LANE_W]))
             + (LANE_W+2)'($signed(lanes[2*LANE_W +: LANE_W]))
             + (LANE_W+2)'($signed(lanes[3*LANE_W +: LANE_W]));
endmodule

// File: rtl/simd_fir_reduce.sv
// simd_fir_reduce: three-stage lane reduction, accumulate across beats, round, shift and saturate
module simd_fir_reduce #(
  parameter int LANES = simd_fir_pkg::LANES,
  parameter int LANE_W = simd_fir_pkg::LANE_W,
  parameter int ACC_W = simd_fir_pkg::ACC_W
) (
  input logic clk,
  input logic rst,
  simd_fir_reduce_if.slave bus
);
  import simd_fir_pkg::*;
  localparam int P_W = LANE_W + 2;
  localparam int S_W = LANE_W + 4;
  localparam int T = LANES / 4;
  logic signed [P_W-1:0] p [T];
  logic signed [P_W-1:0] s1_p [T];
  logic s1_v, s1_last, s2_v, s2_last, stall, sat_hi, sat_lo;
  logic signed [S_W-1:0] p_sum, s2_sum;
  logic signed [ACC_W-1:0] acc, t;
  logic signed [ACC_W:0] rnd, r;
  logic [15:0] sat;
  assign stall = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  for (genvar g = 0; g < T; g++) begin : g_tree
    simd_lane_tree4 u_tree (
      .lanes(bus.in_data[g*4*LANE_W +: 4*LANE_W]),
      .sum(p[g])
    );
  end
  // combine the registered partials into one beat sum
  always_comb begin
    p_sum = '0;
    for (int i = 0; i < T; i++) p_sum = p_sum + S_W'(s1_p[i]);
  end
  // final-sum rounding toward +inf at the half point, then arithmetic shift and clip
  always_comb begin
    t = acc + ACC_W'(s2_sum);
    rnd = (bus.cfg_shift != 5'd0) ? (ACC_W+1)'(1) << (bus.cfg_shift - 5'd1) : '0;
    r = ((ACC_W+1)'(t) + rnd) >>> bus.cfg_shift;
    sat_hi = r > (ACC_W+1)'(SAT_MAX);
    sat_lo = r < (ACC_W+1)'(SAT_MIN);
    sat = sat_hi ? 16'h7fff : sat_lo ? 16'h8000 : r[15:0];
  end
  // whole pipeline freezes while a finished sample waits for the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      s2_v <= 1'b0;
      s2_last <= 1'b0;
      acc <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_sat <= 1'b0;
    end else if (!stall) begin
      s1_p <= p;
      s1_v <= bus.in_valid;
      s1_last <= bus.in_valid & bus.in_last;
      s2_sum <= p_sum;
      s2_v <= s1_v;
      s2_last <= s1_last;
      bus.out_valid <= s2_v & s2_last;
      if (s2_v) acc <= s2_last ? '0 : t;
      if (s2_v & s2_last) begin
        bus.out_data <= sat;
        bus.out_sat <= sat_hi | sat_lo;
      end
    end
  end
endmodule

// File: tb/tb_simd_fir_reduce.sv
// tb_simd_fir_reduce: directed scenarios with hand-computed samples
module tb_simd_fir_reduce;
  logic clk, rst;
  int vectors = 0;
  int miscompares = 0;
  simd_fir_reduce_if bus();
  simd_fir_reduce dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [255:0] splat(input logic [15:0] v);
    return {16{v}};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [255:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) begin
      vectors++; miscompares++;
      $display("FAIL beat_accept: in_ready=%0b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 16'h0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
    vectors++; if (bus.out_sat !== 1'b0) begin miscompares++; $display("FAIL rst_out_sat: got %b want 0", bus.out_sat); end
    rst = 1'b0;
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic test_single();
    bus.cfg_shift = 5'd0;
    beat(splat(16'd1), 1'b1);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_n1: out_valid got %b want 0", bus.out_valid); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_n2: out_valid got %b want 0", bus.out_valid); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_n3: out_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_data !== 16'd16) begin miscompares++; $display("FAIL single_data: got %h want 0010", bus.out_data); end
    vectors++; if (bus.out_sat !== 1'b0) begin miscompares++; $display("FAIL single_sat: got %b want 0", bus.out_sat); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: out_valid got %b want 0", bus.out_valid); end
  endtask
  task automatic test_three_beats();
    bus.cfg_shift = 5'd4;
    beat(splat(16'h0100), 1'b0);
    beat(splat(16'hff00), 1'b0);
    beat(splat(16'h0010), 1'b1);
    tick(); tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd16 || bus.out_sat !== 1'b0) begin
      miscompares++; $display("FAIL three_beats: valid=%b data=%h sat=%b want 1/0010/0", bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
  endtask
  task automatic test_saturation();
    bus.cfg_shift = 5'd0;
    beat(splat(16'h7fff), 1'b1);
    tick(); tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7fff || bus.out_sat !== 1'b1) begin
      miscompares++; $display("FAIL sat_pos: valid=%b data=%h sat=%b want 1/7fff/1", bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
    beat(splat(16'h8000), 1'b1);
    tick(); tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000 || bus.out_sat !== 1'b1) begin
      miscompares++; $display("FAIL sat_neg: valid=%b data=%h sat=%b want 1/8000/1", bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
  endtask
  task automatic test_rounding();
    bus.cfg_shift = 5'd1;
    beat({240'b0, 16'd3}, 1'b1);
    tick(); tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd2 || bus.out_sat !== 1'b0) begin
      miscompares++; $display("FAIL round_pos: valid=%b data=%h sat=%b want 1/0002/0", bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
    beat({240'b0, 16'hfffd}, 1'b1);
    tick(); tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hffff || bus.out_sat !== 1'b0) begin
      miscompares++; $display("FAIL round_neg: valid=%b data=%h sat=%b want 1/ffff/0", bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
  endtask
  task automatic test_backpressure();
    bus.cfg_shift = 5'd0;
    bus.out_ready = 1'b0;
    beat(splat(16'd1), 1'b1);
    beat(splat(16'd2), 1'b1);
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_early: got %b want 1", bus.in_ready); end
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd16 || bus.in_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold%0d: valid=%b data=%h in_ready=%b want 1/0010/0", i, bus.out_valid, bus.out_data, bus.in_ready);
      end
      if (i < 3) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd32) begin
      miscompares++; $display("FAIL bp_second: valid=%b data=%h want 1/0020", bus.out_valid, bus.out_data);
    end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: out_valid got %b want 0", bus.out_valid); end
  endtask
  task automatic test_back_to_back();
    bus.cfg_shift = 5'd0;
    beat(splat(16'd1), 1'b0);
    beat(splat(16'd1), 1'b1);
    beat(splat(16'd3), 1'b1);
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd32) begin
      miscompares++; $display("FAIL b2b_first: valid=%b data=%h want 1/0020", bus.out_valid, bus.out_data);
    end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd48) begin
      miscompares++; $display("FAIL b2b_second: valid=%b data=%h want 1/0030", bus.out_valid, bus.out_data);
    end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid); end
  endtask
  task automatic test_reset_mid();
    bus.cfg_shift = 5'd0;
    beat(splat(16'h1000), 1'b0);
    beat(splat(16'h1000), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL midrst_state: valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    beat(splat(16'd1), 1'b1);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_early: out_valid got %b want 0", bus.out_valid); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd16 || bus.out_sat !== 1'b0) begin
      miscompares++; $display("FAIL midrst_data: valid=%b data=%h sat=%b want 1/0010/0", bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.cfg_shift = 5'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_three_beats();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
